// File: rtl/muldiv_ctrl.sv
// RV32 M-extension multiply/divide controller: single-cycle multiply,
// 32-cycle restoring divide with sign fix-up, and early exit for divide-by-zero/overflow.
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Op_A,
  input  logic [XLEN-1:0] Op_B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return neg_if(x, sgn & x[XLEN-1]);
  endfunction

  // Multiplier: operands sign- or zero-extended to 2*XLEN so one signed product covers all variants
  logic                   mul_a_sgn, mul_b_sgn;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;

  always_comb begin
    mul_a_sgn = (funct3_q[1:0] != 2'b11);
    mul_b_sgn = (funct3_q[1:0] == 2'b01);
    mul_a     = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
    mul_b     = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
    prod      = mul_a * mul_b;
  end

  // Restoring divide step: shift next dividend bit into the partial remainder and trial-subtract
  logic [XLEN:0] shifted, diff;
  logic          div_signed, q_neg, r_neg;

  always_comb begin
    shifted    = {rem_q, quo_q[XLEN-1]};
    diff       = shifted - {1'b0, dvs_q};
    div_signed = ~funct3_q[0];
    q_neg      = div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg      = div_signed & a_q[XLEN-1];
  end

  // Early-exit cases are decided from the live inputs in the Start cycle
  logic            in_signed, in_div0, in_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    in_signed = ~Funct3[0];
    in_div0   = (Op_B == '0);
    in_ovf    = in_signed && (Op_A == {1'b1, {(XLEN-1){1'b0}}}) && (Op_B == '1);
    if (in_div0)
      special_res = Funct3[1] ? Op_A : '1;
    else
      special_res = Funct3[1] ? '0 : Op_A;
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          funct3_d = Funct3;
          a_d      = Op_A;
          b_d      = Op_B;
          busy_d   = 1'b1;
          if (!Funct3[2]) begin
            state_d = S_MUL;
          end else if (in_div0 || in_ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
          end else begin
            state_d = S_DIV;
            quo_d   = mag(Op_A, in_signed);
            dvs_d   = mag(Op_B, in_signed);
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_MUL: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        result_d = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
      S_DIV: begin
        rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        result_d = funct3_q[1] ? neg_if(rem_q, r_neg) : neg_if(quo_q, q_neg);
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush wins over everything, including a Start in the same cycle
    if (Flush) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues expected result and Done cycle,
// a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        Flush;
  logic [2:0]  Funct3;
  logic [31:0] Op_A;
  logic [31:0] Op_B;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .Flush  (Flush),
    .Funct3 (Funct3),
    .Op_A   (Op_A),
    .Op_B   (Op_B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got time %0t required < 200000", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d with Result 0x%08h, required no Done", cyc, Result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, Result, e.res);
        chk({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string nm);
    Start  = 1'b1;
    Funct3 = f3;
    Op_A   = a;
    Op_B   = b;
    exp_q.push_back('{exp_res, cyc + lat, nm});
    step();
    Start = 1'b0;
    repeat (lat) step();
  endtask

  initial begin
    rst    = 1'b1;
    Start  = 1'b0;
    Flush  = 1'b0;
    Funct3 = 3'b000;
    Op_A   = '0;
    Op_B   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    rst = 1'b0;
    step();

    issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  "mul");
    issue(3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 2,  "mulhu");
    issue(3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2,  "mulh");
    issue(3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 34, "div");
    issue(3'b110, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 34, "rem");
    issue(3'b101, 32'd100,       32'd7,         32'd14,        34, "divu");
    issue(3'b111, 32'd100,       32'd7,         32'd2,         34, "remu");
    issue(3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1,  "divu_by0");
    issue(3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1,  "remu_by0");
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");
    issue(3'b110, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFEC, 1,  "rem_by0");

    // Flush a DIV at t+10, then MULHSU immediately afterwards
    Start  = 1'b1;
    Funct3 = 3'b100;
    Op_A   = 32'hFFFF_FFEC;
    Op_B   = 32'h0000_0006;
    step();
    Start = 1'b0;
    repeat (9) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_busy", {31'b0, Busy}, 32'd0);
    chk("flush_result_held", Result, 32'hFFFF_FFEC);
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2, "mulhsu");

    // Reset mid-DIVU with Start held high; the held Start must not restart anything
    Start  = 1'b1;
    Funct3 = 3'b101;
    Op_A   = 32'd100;
    Op_B   = 32'd7;
    exp_q.push_back('{32'd14, cyc + 34, "divu_abandoned"});
    step();
    Funct3 = 3'b000;
    Op_A   = 32'd5;
    Op_B   = 32'd5;
    for (int i = 1; i <= 4; i++) begin
      chk("held_start_busy", {31'b0, Busy}, 32'd1);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_busy", {31'b0, Busy}, 32'd0);
    chk("midreset_done", {31'b0, Done}, 32'd0);
    chk("midreset_result", Result, 32'd0);
    exp_q.delete();
    Start = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_after_reset");

    repeat (5) step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port Flush  input  1  abort current operation (pipeline flush).
REQ-006 SHALL have port Funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port Op_A  input  32  rs1 operand.
REQ-008 SHALL have port Op_B  input  32  rs2 operand.
REQ-009 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; Result valid in that cycle.
REQ-011 SHALL have port Result  output  32  rd value; holds its last value until the next Done.

Function
REQ-012 SHALL implement an FSM with states IDLE, MUL, DIV, FIX, DONE.
REQ-013 SHALL, in IDLE with Start=1 and Flush=0, register Funct3, Op_A and Op_B; Start in any other state SHALL be ignored.
REQ-014 SHALL go IDLE->MUL for Funct3[2]=0; MUL computes the 64-bit product in one cycle and goes to DONE.
REQ-015 SHALL return low 32 bits for MUL; high 32 bits for MULH (s*s), MULHSU (s*u), and MULHU (u*u).
REQ-016 SHALL go IDLE->DIV for Funct3[2]=1 unless REQ-019 or REQ-020 applies.
REQ-017 SHALL, in DIV, run restoring division on operand magnitudes (signed ops) or raw values (unsigned ops): 1 quotient bit per cycle, 6-bit counter, exactly 32 cycles, then go to FIX.
REQ-018 SHALL, in FIX, apply signs: quotient negated if the operand signs differ (signed ops); remainder takes Op_A's sign; then go to DONE.
REQ-019 SHALL handle divide by zero (Op_B=0) in IDLE, going directly to DONE: DIV/DIVU return 0xFFFFFFFF; REM/REMU return Op_A.
REQ-020 SHALL handle signed overflow (Op_A=0x80000000, Op_B=0xFFFFFFFF) in IDLE, going directly to DONE: DIV returns 0x80000000; REM returns 0.
REQ-021 SHALL use these latencies from the Start-sampled cycle t, with Done high in the listed cycle:
- multiply: t+2
- divide: t+34
- special cases: t+1
REQ-022 SHALL, in DONE, assert Done for exactly one cycle, load Result, and return to IDLE.
REQ-023 SHALL accept a new Start in the cycle after Done; back-to-back ops have no extra bubble.
REQ-024 SHALL, on Flush=1 in any state, go to IDLE on the next edge with no Done and Result unchanged.
REQ-025 SHALL give Flush priority over Start in the same cycle.
REQ-026 SHALL keep operand registers stable during DIV, so input changes after Start have no effect.

Reset
REQ-027 SHALL, while rst is high, force:
- state to IDLE
- Busy=0, Done=0, Result=0
- counter and internal registers to 0
REQ-028 SHALL, on reset mid-operation, abandon the operation immediately; the first Start after rst falls is serviced normally.

Verification
REQ-029 SHALL check: MUL, A=0x00000007, B=0xFFFFFFFD -> Done at t+2, Result=0xFFFFFFEB; MULHU on the same operands -> 0x00000006.
REQ-030 SHALL check: DIV, A=0xFFFFFFEC (-20), B=0x00000006 -> Done at t+34, Result=0xFFFFFFFD; REM -> 0xFFFFFFFE.
REQ-031 SHALL check: DIVU, A=0x12345678, B=0 -> Done at t+1, Result=0xFFFFFFFF; REMU -> 0x12345678.
REQ-032 SHALL check: DIV, A=0x80000000, B=0xFFFFFFFF -> Done at t+1, Result=0x80000000; REM -> 0.
REQ-033 SHALL check: DIV started, Flush at t+10 -> Busy=0 at t+11, no Done; a new MULHSU (A=0xFFFFFFFF, B=2) at t+11 -> Result=0xFFFFFFFF at t+13.
REQ-034 SHALL check: rst asserted at t+5 of a DIVU, with Start held high during DIV -> outputs zero immediately; the Start held during DIV was ignored.
